unibus_master: RTL and testbench

- ARM-driven bus initiator; the other end of the slave-side register protocol used by our device blocks (dl11 etc.).
- ARM loads address, function and write data, then starts one DATI/DATIP/DATO/DATOB cycle. Block arbitrates for the bus, runs MSYN/SSYN, latches read data and reports done/timeout.
- Sits beside the device blocks on the same ARM register bus and Unibus signal set. Used by the ARM for memory/IO examine/deposit.

---
 rtl/unibus_master_pkg.sv | 21 ++
 rtl/unibus_master.sv | 200 ++++++++++++++++++++
 tb/tb_unibus_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unibus_master_pkg.sv
// rtl/unibus_master_pkg.sv - shared constants and state type for unibus_master
package unibus_master_pkg;

  localparam logic [1:0] FN_DATI  = 2'd0;
  localparam logic [1:0] FN_DATIP = 2'd1;
  localparam logic [1:0] FN_DATO  = 2'd2;
  localparam logic [1:0] FN_DATOB = 2'd3;

  localparam logic [31:0] UM_ID = 32'h424D1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SETUP,
    ST_WAITA,
    ST_LATCH,
    ST_WAITN,
    ST_DONE
  } um_state_e;

endpackage

// File: rtl/unibus_master.sv
// rtl/unibus_master.sv - Unibus initiator running one ARM-requested DATI/DATIP/DATO/DATOB cycle
module unibus_master
  import unibus_master_pkg::*;
#(
  parameter int unsigned SETUP   = 15,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        init_in_h,
  input  logic        bbsy_in_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        msyn_out_h,
  output logic        bbsy_out_h
);

  localparam logic [15:0] SETUP_LD = 16'(SETUP);
  localparam logic [15:0] TMO_LD   = 16'(TIMEOUT);
  localparam logic [7:0]  SETUP_RD = 8'(SETUP);

  um_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d, tmo_q, tmo_d;
  logic [17:0] addr_q, addr_d;
  logic [1:0]  func_q, func_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [17:0] a_q, a_d;
  logic [1:0]  c_q, c_d;
  logic [15:0] d_q, d_d;
  logic        msyn_q, msyn_d, bbsy_q, bbsy_d;
  logic        is_wr;
  logic        unused_wdata;

  assign is_wr        = (func_q == FN_DATO) || (func_q == FN_DATOB);
  assign unused_wdata = ^armwdata[30:20];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      func_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      a_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      msyn_q  <= 1'b0;
      bbsy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      func_q  <= func_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      a_q     <= a_d;
      c_q     <= c_d;
      d_q     <= d_d;
      msyn_q  <= msyn_d;
      bbsy_q  <= bbsy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    func_d  = func_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    a_d     = a_q;
    c_d     = c_q;
    d_d     = d_q;
    msyn_d  = msyn_q;
    bbsy_d  = bbsy_q;
    if (init_in_h) begin
      // bus INIT aborts any cycle in flight but keeps the ARM-visible registers
      state_d = ST_IDLE;
      a_d     = '0;
      c_d     = '0;
      d_d     = '0;
      msyn_d  = 1'b0;
      bbsy_d  = 1'b0;
      if (busy_q) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        tmo_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ARB: begin
          if (!bbsy_in_h) begin
            bbsy_d  = 1'b1;
            a_d     = addr_q;
            c_d     = func_q;
            d_d     = is_wr ? wdata_q : 16'd0;
            cnt_d   = SETUP_LD;
            state_d = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 16'd0) begin
            msyn_d  = 1'b1;
            cnt_d   = TMO_LD;
            state_d = ST_WAITA;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_WAITA: begin
          if (ssyn_in_h) begin
            state_d = ST_LATCH;
          end else if (cnt_q == 16'd0) begin
            tmo_d   = 1'b1;
            msyn_d  = 1'b0;
            cnt_d   = TMO_LD;
            state_d = ST_WAITN;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_LATCH: begin
          // one clock after SSYN lets the slave's data settle before sampling
          if (!is_wr) rdata_d = d_in_h;
          msyn_d  = 1'b0;
          cnt_d   = TMO_LD;
          state_d = ST_WAITN;
        end
        ST_WAITN: begin
          if (!ssyn_in_h) begin
            state_d = ST_DONE;
          end else if (cnt_q == 16'd0) begin
            tmo_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_DONE: begin
          a_d     = '0;
          c_d     = '0;
          d_d     = '0;
          bbsy_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (armwrite && armwaddr == 2'd1 && !busy_q) begin
        func_d = armwdata[19:18];
        addr_d = armwdata[17:0];
        done_d = 1'b0;
        tmo_d  = 1'b0;
        if (armwdata[31]) begin
          busy_d  = 1'b1;
          state_d = ST_ARB;
        end
      end
      if (armwrite && armwaddr == 2'd2) wdata_d = armwdata[15:0];
    end
  end

  always_comb begin
    armrdata = UM_ID;
    case (armraddr)
      2'd0: armrdata = UM_ID;
      2'd1: armrdata = {busy_q, done_q, tmo_q, 9'b0, func_q, addr_q};
      2'd2: armrdata = {rdata_q, wdata_q};
      default: armrdata = {TMO_LD, 8'h00, SETUP_RD};
    endcase
  end

  assign a_out_h    = a_q;
  assign c_out_h    = c_q;
  assign d_out_h    = d_q;
  assign msyn_out_h = msyn_q;
  assign bbsy_out_h = bbsy_q;

endmodule

// File: tb/tb_unibus_master.sv
// tb/tb_unibus_master.sv - self-checking bench for unibus_master against a timeline model
module tb_unibus_master;

  localparam int SET = 15;
  localparam int TMO = 1000;

  logic        CLOCK = 1'b0, RESET = 1'b0, armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0, armwaddr = 2'd0;
  logic [31:0] armwdata = 32'd0;
  logic        init_in_h = 1'b0, bbsy_in_h = 1'b0, ssyn_in_h = 1'b0;
  logic [15:0] d_in_h = 16'd0;
  logic [31:0] armrdata;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;
  logic        msyn_out_h, bbsy_out_h;

  int errors = 0, checks = 0;
  logic cmp_en = 1'b0;

  unibus_master #(.SETUP(SET), .TIMEOUT(TMO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
    .init_in_h(init_in_h), .bbsy_in_h(bbsy_in_h), .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h),
    .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h),
    .msyn_out_h(msyn_out_h), .bbsy_out_h(bbsy_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register file plus edge timestamps of the cycle's milestones
  logic        m_busy, m_done, m_tmo, m_busy_pre;
  logic [17:0] m_addr, m_a;
  logic [1:0]  m_func, m_c;
  logic [15:0] m_wdata, m_rdata, m_d;
  logic        m_msyn, m_bbsy;
  int cyc, t_arb, t_own, t_ack, t_fall, t_neg;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      {m_busy, m_done, m_tmo, m_msyn, m_bbsy} = '0;
      m_addr = '0; m_func = '0; m_wdata = '0; m_rdata = '0;
      m_a = '0; m_c = '0; m_d = '0;
      cyc = 0; t_arb = -1;
    end else begin
      cyc++;
      m_busy_pre = m_busy;
      if (init_in_h) begin
        m_a = '0; m_c = '0; m_d = '0; m_msyn = 1'b0; m_bbsy = 1'b0;
        if (m_busy) begin m_busy = 1'b0; m_done = 1'b1; m_tmo = 1'b1; end
        t_arb = -1;
      end else begin
        if (t_arb >= 0) begin
          if (t_own < 0) begin
            if (!bbsy_in_h) begin
              t_own = cyc; m_bbsy = 1'b1; m_a = m_addr; m_c = m_func;
              m_d = m_func[1] ? m_wdata : 16'd0;
            end
          end else if (t_fall < 0) begin
            if (cyc == t_own + SET + 1) m_msyn = 1'b1;
            else if (cyc > t_own + SET + 1) begin
              if (t_ack >= 0) begin
                m_msyn = 1'b0; t_fall = cyc;
                if (!m_func[1]) m_rdata = d_in_h;
              end else if (ssyn_in_h) t_ack = cyc;
              else if (cyc == t_own + SET + 1 + TMO + 1) begin
                m_msyn = 1'b0; m_tmo = 1'b1; t_fall = cyc;
              end
            end
          end else if (t_neg < 0) begin
            if (!ssyn_in_h) t_neg = cyc;
            else if (cyc == t_fall + TMO + 1) begin m_tmo = 1'b1; t_neg = cyc; end
          end else begin
            m_a = '0; m_c = '0; m_d = '0; m_bbsy = 1'b0;
            m_busy = 1'b0; m_done = 1'b1; t_arb = -1;
          end
        end
        if (armwrite && armwaddr == 2'd1 && !m_busy_pre) begin
          m_func = armwdata[19:18]; m_addr = armwdata[17:0]; m_done = 1'b0; m_tmo = 1'b0;
          if (armwdata[31]) begin
            m_busy = 1'b1; t_arb = cyc; t_own = -1; t_ack = -1; t_fall = -1; t_neg = -1;
          end
        end
        if (armwrite && armwaddr == 2'd2) m_wdata = armwdata[15:0];
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] r);
    case (r)
      2'd0: return 32'h424D1001;
      2'd1: return {m_busy, m_done, m_tmo, 9'b0, m_func, m_addr};
      2'd2: return {m_rdata, m_wdata};
      default: return {16'(TMO), 8'h00, 8'(SET)};
    endcase
  endfunction

  always @(negedge CLOCK) begin
    if (cmp_en) begin
      chk("bus", {a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h},
          {m_a, m_c, m_d, m_msyn, m_bbsy});
      chk("armrdata", armrdata, exp_rd(armraddr));
    end
  end

  // Slave: raises SSYN slave_dly clocks after MSYN, drops it rel_dly clocks after MSYN falls
  logic        slave_en = 1'b0;
  int          slave_dly = 0, rel_dly = 0, sl_cnt = 0;
  logic [15:0] slave_data = 16'd0;

  initial begin
    forever begin
      @(posedge CLOCK); #1;
      if (slave_en && msyn_out_h && !ssyn_in_h) begin
        if (sl_cnt == slave_dly) begin ssyn_in_h = 1'b1; d_in_h = slave_data; sl_cnt = 0; end
        else sl_cnt++;
      end else if (ssyn_in_h && !msyn_out_h) begin
        if (sl_cnt == rel_dly) begin ssyn_in_h = 1'b0; d_in_h = 16'($urandom); sl_cnt = 0; end
        else sl_cnt++;
      end else if (!msyn_out_h) sl_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge CLOCK); #1;
    armraddr = 2'($urandom_range(0, 3));
  endtask

  task automatic arm_write(input logic [1:0] r, input logic [31:0] v);
    @(posedge CLOCK); #1;
    armwrite = 1'b1; armwaddr = r; armwdata = v;
    @(posedge CLOCK); #1;
    armwrite = 1'b0; armwdata = 32'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0; armraddr = 2'd1; #1;
    while (armrdata[31] && n < 3000) begin @(posedge CLOCK); #1; n++; end
    chk({name, "_idle"}, armrdata[31], 1'b0);
  endtask

  task automatic wait_msyn(input string name);
    int n;
    n = 0;
    while (!msyn_out_h && n < 200) begin @(posedge CLOCK); #1; n++; end
    chk({name, "_msyn"}, msyn_out_h, 1'b1);
  endtask

  task automatic wait_ssyn_low();
    int n;
    n = 0;
    while (ssyn_in_h && n < 2000) begin tick(); n++; end
    chk("ssyn_release", ssyn_in_h, 1'b0);
  endtask

  initial begin
    errors = 1_000_000;
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int n;
    logic held;
    errors = 0;
    #1 RESET = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1 RESET = 1'b0;
    cmp_en = 1'b1;

    armraddr = 2'd0; #1 chk("id", armrdata, 32'h424D1001);
    armraddr = 2'd3; #1 chk("params", armrdata, 32'h03E8000F);
    armraddr = 2'd1; #1 chk("reset_reg1", armrdata, 32'h0);
    armraddr = 2'd2; #1 chk("reset_reg2", armrdata, 32'h0);
    chk("reset_bus", {a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h}, 38'h0);

    // DATI from 777560, slave answers 5 clocks after MSYN
    slave_en = 1'b1; slave_dly = 5; rel_dly = 2; slave_data = 16'o000200;
    arm_write(2'd1, {1'b1, 11'b0, 2'b00, 18'o777560});
    n = 0;
    while (!bbsy_out_h && n < 100) begin @(posedge CLOCK); #1; n++; end
    n = 0;
    while (!msyn_out_h && n < 100) begin @(posedge CLOCK); #1; n++; end
    chk("dati_setup_gap", n, 16);
    chk("dati_addr", a_out_h, 18'o777560);
    wait_idle("dati");
    chk("dati_status", armrdata[31:29], 3'b010);
    chk("dati_bus_end", {a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h}, 38'h0);
    armraddr = 2'd2; #1 chk("dati_rdata", armrdata[31:16], 16'o000200);
    wait_ssyn_low();

    // DATOB to 777566
    arm_write(2'd2, 32'o123456);
    arm_write(2'd1, {1'b1, 11'b0, 2'b11, 18'o777566});
    wait_msyn("datob");
    chk("datob_d", d_out_h, 16'o123456);
    chk("datob_c", c_out_h, 2'b11);
    wait_idle("datob");
    armraddr = 2'd2; #1 chk("datob_rdata", armrdata, {16'o000200, 16'o123456});
    wait_ssyn_low();

    // No slave: MSYN dropped by the timeout
    slave_en = 1'b0;
    arm_write(2'd1, {1'b1, 11'b0, 2'b00, 18'o760000});
    wait_msyn("nxm");
    n = 0;
    while (msyn_out_h && n < 3000) begin @(posedge CLOCK); #1; n++; end
    chk("nxm_msyn_width", n, TMO + 1);
    wait_idle("nxm");
    chk("nxm_status", armrdata[31:29], 3'b011);
    armraddr = 2'd2; #1 chk("nxm_rdata", armrdata[31:16], 16'o000200);

    // Arbitration held off by another master for 50 clocks
    slave_en = 1'b1; slave_dly = 1; rel_dly = 1; slave_data = 16'o1234;
    bbsy_in_h = 1'b1;
    arm_write(2'd1, {1'b1, 11'b0, 2'b01, 18'o777570});
    held = 1'b0;
    repeat (50) begin @(posedge CLOCK); #1; if (bbsy_out_h) held = 1'b1; end
    chk("arb_hold", held, 1'b0);
    bbsy_in_h = 1'b0; n = 0;
    do begin @(posedge CLOCK); #1; n++; end while (!bbsy_out_h && n < 10);
    chk("arb_grant_delay", n, 1);
    wait_idle("arb");
    wait_ssyn_low();

    // INIT during WAITA
    slave_en = 1'b0;
    arm_write(2'd1, {1'b1, 11'b0, 2'b00, 18'o777560});
    wait_msyn("abort");
    @(posedge CLOCK); #1 init_in_h = 1'b1;
    @(posedge CLOCK); #1 init_in_h = 1'b0;
    chk("abort_bus", {a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h}, 38'h0);
    armraddr = 2'd1; #1;
    chk("abort_status", armrdata[31:29], 3'b011);
    chk("abort_addr", armrdata[17:0], 18'o777560);

    // Reg 1 write while busy is ignored
    slave_en = 1'b1; slave_dly = 3; rel_dly = 0; slave_data = 16'o7;
    arm_write(2'd1, {1'b1, 11'b0, 2'b00, 18'o777570});
    arm_write(2'd1, {1'b1, 11'b0, 2'b10, 18'o000123});
    armraddr = 2'd1; #1 chk("busy_write_ignored", armrdata[19:0], {2'b00, 18'o777570});
    wait_idle("busy_write");
    wait_ssyn_low();

    // Randomized cycles
    for (int i = 0; i < 30; i++) begin
      int mode, hold;
      logic [31:0] w;
      mode = $urandom_range(0, 9);
      slave_en = (mode != 0);
      slave_dly = $urandom_range(0, 8);
      rel_dly = (mode == 1) ? 1200 : $urandom_range(0, 4);
      slave_data = 16'($urandom);
      if ($urandom_range(0, 1) == 1) arm_write(2'd2, $urandom);
      if ($urandom_range(0, 3) == 0) arm_write(2'd1, $urandom & 32'h7FFF_FFFF);
      hold = $urandom_range(0, 4);
      bbsy_in_h = (hold != 0);
      w = $urandom; w[31] = 1'b1;
      arm_write(2'd1, w);
      repeat (hold) tick();
      bbsy_in_h = 1'b0;
      if ($urandom_range(0, 2) == 0) begin tick(); arm_write(2'd2, $urandom); end
      wait_idle("rnd");
      wait_ssyn_low();
    end

    // Asynchronous RESET in the middle of a cycle
    slave_en = 1'b1; slave_dly = 20; rel_dly = 0;
    arm_write(2'd2, 32'h0000_5A5A);
    arm_write(2'd1, {1'b1, 11'b0, 2'b10, 18'o777570});
    wait_msyn("areset");
    @(posedge CLOCK); #3 RESET = 1'b1;
    #1 chk("areset_bus", {a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h}, 38'h0);
    armraddr = 2'd1; #1 chk("areset_reg1", armrdata, 32'h0);
    armraddr = 2'd2; #1 chk("areset_reg2", armrdata, 32'h0);
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
